match_timer: RTL and testbench
==============================

Name: match_timer

Overview:
- Parametrised round timer for the pong time mode, replacing the fixed 20 s countdown and the derived 1 Hz clock.
- Runs on the single system clock. Tick and scan strobes are generated internally as clock enables.
- Holds an NDIG-digit BCD count that counts down to zero, or up to a target, with start, pause and load control.
- Drives a multiplexed active-low 7-segment display and gives expiry status to the game FSM.

Parameters:
- CLK_HZ, 100000000, system clock frequency. Must be an integer multiple of TICK_HZ and REFRESH_HZ.
- TICK_HZ, 1, count rate in ticks per second.
- REFRESH_HZ, 1000, rate at which the display advances to the next digit.
- NDIG, 4, number of BCD digits and anodes. Range 1..8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load  in  1  1-cycle strobe: capture load_bcd and enter IDLE
- load_bcd  in  4*NDIG  BCD load value; digit 0 is bits [3:0]
- up_mode  in  1  sampled on load. 0 = count down from load_bcd to 0; 1 = count up from 0 to load_bcd
- start  in  1  1-cycle strobe: run or resume
- pause  in  1  1-cycle strobe: pause
- running  out  1  high while in RUN
- expired  out  1  high while in EXPIRED
- expire_pulse  out  1  single-cycle pulse on entry to EXPIRED
- count_bcd  out  4*NDIG  current count
- seg  out  7  segments {g..a}, active low
- an  out  NDIG  anodes, active low, exactly one low

Behaviour:
- Reset is synchronous and active-high. While reset is high on a clock edge:
  - state = IDLE, count = 0, target = 0, mode = down, prescaler = 0, scan index = 0.
  - running = 0, expired = 0, expire_pulse = 0.
  - an = all 1, seg = 7'h7F.
  - Reset asserted mid-run aborts immediately. No expire_pulse is produced.
- All outputs are registered.
- Display is updated every cycle from the scan index and count.
  - First cycle after reset release: an = ~1, seg = 7'b1000000 (digit 0 showing "0").
- Load digit sanitising: any load_bcd digit greater than 9 is stored as 9.
- Prescaler:
  - Counts 0..CLK_HZ/TICK_HZ-1, but only in RUN.
  - tick is asserted for one cycle at the terminal value, then the prescaler wraps to 0.
  - Cleared on load and on reset. Holds its value in PAUSE, so resume keeps the partial second.
- Scan counter:
  - Free-running divider of CLK_HZ/REFRESH_HZ cycles.
  - Scan index wraps from NDIG-1 to 0.
- Command priority in a single cycle: reset > load > start > pause.
- States and transitions:
  - IDLE:
    - load: down mode sets count = load_bcd; up mode sets count = 0 and target = load_bcd. Stays in IDLE.
    - start: goes to RUN. If count is already terminal (down: 0; up: count == target), goes to EXPIRED instead.
  - RUN:
    - On tick, BCD decrement (down) or BCD increment (up) with digit borrow/carry.
    - If the new count is terminal, the same edge goes to EXPIRED and sets expire_pulse = 1 for one cycle.
    - pause goes to PAUSE.
    - load goes to IDLE.
  - PAUSE:
    - start goes to RUN.
    - load goes to IDLE.
    - Count is frozen.
  - EXPIRED:
    - Count is held at the terminal value.
    - start and pause are ignored.
    - load goes to IDLE.
- Wrap-around: count never passes 0 (down) or target (up). It cannot reach 10^NDIG-1+1.
- Strobes that do not apply in the current state are ignored with no side effects.

Optional Feature:
- Macro: MATCH_TIMER_BLINK_EN.
- Defined: while in EXPIRED, the display blanks (an = all 1) for alternate half-periods of TICK_HZ*2. The phase starts visible on entry.
- Not defined: the display is steady in EXPIRED.
- running, expired, expire_pulse and count_bcd are identical in both builds.

Decomposition:
- Package match_timer_pkg holds:
  - state encoding (IDLE, RUN, PAUSE, EXPIRED)
  - the 16-entry BCD-to-segment table (entries 10..15 are blank)
  - constant SEG_BLANK = 7'h7F
- Natural sub-module: seg7_scan. It contains the scan divider, anode rotation and segment lookup, taking count_bcd and a blank input.

Test Plan (CLK_HZ=100, TICK_HZ=1, REFRESH_HZ=25, NDIG=4):
- Down count: load 0x0020 in down mode, then start → count 0x0019 after 100 cycles. After 2000 cycles: count 0x0000, expire_pulse high for exactly 1 cycle, expired = 1, running = 0.
- Up count with carry: load 0x0105 in up mode, start → count passes 0x0009 → 0x0010 and 0x0099 → 0x0100. Expires at 0x0105 after 10500 cycles.
- Pause/resume: start a load of 0x0003, pause at cycle 150, hold 500 cycles, then start → count 0x0002 stays frozen during the pause. The next tick comes 50 cycles after resume.
- Priority: load, start and pause asserted in the same cycle while in RUN → state = IDLE, count = load value. start with count 0 in down mode → EXPIRED next cycle with a pulse.
- Sanitise and reset: load 0x00AF → count 0x0099. Reset asserted mid-RUN → all outputs at reset values next cycle, no expire_pulse.
- Scan: count 0x1234 → an cycles 1110, 1101, 1011, 0111 every 4 cycles with the matching seg codes. With MATCH_TIMER_BLINK_EN in EXPIRED, an = 1111 for 50 of every 100 cycles.

Source files
------------

// File: rtl/match_timer_pkg.sv
// Shared types and constants for the match timer: FSM states and the
// active-low BCD-to-7-segment table ({g..a}).
package match_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 15 is leftmost; codes 10..15 are blank.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/match_timer_seg7_scan.sv
// Multiplexed 7-segment driver: free-running scan divider, one-hot-low
// anode rotation and registered segment lookup of the selected BCD digit.
module match_timer_seg7_scan
    import match_timer_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int REFRESH_HZ = 1000,
    parameter int NDIG       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4*NDIG-1:0] count_bcd,
    input  logic              blank,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an
);

    localparam int SCAN_DIV = CLK_HZ / REFRESH_HZ;
    localparam int DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    logic [DIV_W-1:0] div_q;
    logic [IDX_W-1:0] idx_q;
    logic [6:0]       seg_q;
    logic [NDIG-1:0]  an_q;
    logic [3:0]       digit_d;

    assign digit_d = count_bcd[4*idx_q +: 4];

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
            if (blank) begin
                seg_q <= SEG_BLANK;
                an_q  <= '1;
            end else begin
                seg_q <= SEG_TABLE[digit_d];
                an_q  <= ~(NDIG'(1) << idx_q);
            end
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: rtl/match_timer.sv
// Parametrised BCD round timer (count down to 0 or up to a target) with
// start/pause/load control; MATCH_TIMER_BLINK_EN blinks the display when expired.
module match_timer
    import match_timer_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int TICK_HZ    = 1,
    parameter int REFRESH_HZ = 1000,
    parameter int NDIG       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_bcd,
    input  logic              up_mode,
    input  logic              start,
    input  logic              pause,
    output logic              running,
    output logic              expired,
    output logic              expire_pulse,
    output logic [4*NDIG-1:0] count_bcd,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an
);

    localparam int W        = 4 * NDIG;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_e         state_q;
    logic [W-1:0]   count_q;
    logic [W-1:0]   target_q;
    logic           up_q;
    logic [PW-1:0]  presc_q;
    logic           running_q;
    logic           expired_q;
    logic           pulse_q;

    logic [W-1:0]   load_val_d;
    logic [W-1:0]   step_d;
    logic           tick_d;
    logic           step_term_d;
    logic           cur_term_d;
    logic           blank_d;

    function automatic logic [W-1:0] bcd_sanitise(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            d = v[4*i +: 4];
            r[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (d == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            d = v[4*i +: 4];
            if (b) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign load_val_d  = bcd_sanitise(load_bcd);
    assign tick_d      = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign step_d      = up_q ? bcd_inc(count_q) : bcd_dec(count_q);
    assign step_term_d = up_q ? (step_d == target_q) : (step_d == '0);
    assign cur_term_d  = up_q ? (count_q == target_q) : (count_q == '0);

    // A terminal tick wins over a pause arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            target_q  <= '0;
            up_q      <= 1'b0;
            presc_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (load) begin
                state_q   <= ST_IDLE;
                presc_q   <= '0;
                up_q      <= up_mode;
                running_q <= 1'b0;
                expired_q <= 1'b0;
                if (up_mode) begin
                    count_q  <= '0;
                    target_q <= load_val_d;
                end else begin
                    count_q <= load_val_d;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if (cur_term_d) begin
                                state_q   <= ST_EXPIRED;
                                expired_q <= 1'b1;
                                pulse_q   <= 1'b1;
                            end else begin
                                state_q   <= ST_RUN;
                                running_q <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        presc_q <= tick_d ? '0 : presc_q + PW'(1);
                        if (tick_d) begin
                            count_q <= step_d;
                        end
                        if (tick_d && step_term_d) begin
                            state_q   <= ST_EXPIRED;
                            running_q <= 1'b0;
                            expired_q <= 1'b1;
                            pulse_q   <= 1'b1;
                        end else if (pause) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        if (start) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_EXPIRED: begin
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef MATCH_TIMER_BLINK_EN
    localparam int HALF = CLK_HZ / (2 * TICK_HZ);
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);

    logic [BW-1:0] blink_cnt_q;
    logic          blink_ph_q;

    // Phase restarts visible every time EXPIRED is entered.
    always_ff @(posedge clk) begin
        if (reset || state_q != ST_EXPIRED) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else if (blink_cnt_q == HALF_LAST) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= ~blink_ph_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
        end
    end

    assign blank_d = (state_q == ST_EXPIRED) && blink_ph_q;
`else
    assign blank_d = 1'b0;
`endif

    match_timer_seg7_scan #(
        .CLK_HZ    (CLK_HZ),
        .REFRESH_HZ(REFRESH_HZ),
        .NDIG      (NDIG)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .count_bcd(count_q),
        .blank    (blank_d),
        .seg      (seg),
        .an       (an)
    );

    assign running      = running_q;
    assign expired      = expired_q;
    assign expire_pulse = pulse_q;
    assign count_bcd    = count_q;

endmodule

// File: tb/tb_match_timer.sv
// Self-checking bench for match_timer: integer-level reference model checked
// every cycle, directed scenarios with literal expectations, then random strobes.
module tb_match_timer;

    localparam int CLK_HZ     = 100;
    localparam int TICK_HZ    = 1;
    localparam int REFRESH_HZ = 25;
    localparam int NDIG       = 4;
    localparam int TICK_DIV   = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV   = CLK_HZ / REFRESH_HZ;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] load_bcd;
    logic        up_mode;
    logic        start;
    logic        pause;
    logic        running;
    logic        expired;
    logic        expire_pulse;
    logic [15:0] count_bcd;
    logic [6:0]  seg;
    logic [3:0]  an;

    match_timer #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .REFRESH_HZ(REFRESH_HZ),
        .NDIG      (NDIG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_bcd    (load_bcd),
        .up_mode     (up_mode),
        .start       (start),
        .pause       (pause),
        .running     (running),
        .expired     (expired),
        .expire_pulse(expire_pulse),
        .count_bcd   (count_bcd),
        .seg         (seg),
        .an          (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int pulse_seen = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (decimal integers) ----------------
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} mstate_t;
    mstate_t    m_st;
    int         m_cnt, m_tgt, m_presc, m_scan, m_idx;
    bit         m_up, m_pulse, m_ticked, m_blank;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    logic [15:0] m_cb;
`ifdef MATCH_TIMER_BLINK_EN
    localparam int HALF = CLK_HZ / (2 * TICK_HZ);
    int m_expn;
`endif

    function automatic int bcd_value(input logic [15:0] v);
        int n, d;
        n = 0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            n = n * 10 + ((d > 9) ? 9 : d);
        end
        return n;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int k;
        k = n;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(k % 10);
            k = k / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic bit at_end(input bit up, input int c, input int t);
        return up ? (c == t) : (c == 0);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_st = M_IDLE; m_cnt = 0; m_tgt = 0; m_up = 1'b0; m_presc = 0;
            m_scan = 0; m_pulse = 1'b0; m_an = 4'hF; m_seg = 7'h7F;
`ifdef MATCH_TIMER_BLINK_EN
            m_expn = 0;
`endif
            chk_en = 1'b1;
        end else begin
            m_cb    = to_bcd(m_cnt);
            m_idx   = (m_scan / SCAN_DIV) % NDIG;
            m_blank = 1'b0;
`ifdef MATCH_TIMER_BLINK_EN
            if (m_st == M_EXP) begin
                m_blank = ((m_expn / HALF) % 2) == 1;
                m_expn++;
            end else begin
                m_expn = 0;
            end
`endif
            m_an  = m_blank ? 4'hF : ~(4'b0001 << m_idx);
            m_seg = m_blank ? 7'h7F : seg_of(m_cb[4*m_idx +: 4]);
            m_scan++;
            m_pulse = 1'b0;
            if (load) begin
                m_st = M_IDLE; m_presc = 0; m_up = up_mode;
                if (up_mode) begin
                    m_cnt = 0; m_tgt = bcd_value(load_bcd);
                end else begin
                    m_cnt = bcd_value(load_bcd);
                end
            end else begin
                case (m_st)
                    M_IDLE: if (start) begin
                        if (at_end(m_up, m_cnt, m_tgt)) begin
                            m_st = M_EXP; m_pulse = 1'b1;
                        end else m_st = M_RUN;
                    end
                    M_RUN: begin
                        m_presc++;
                        m_ticked = (m_presc == TICK_DIV);
                        if (m_ticked) begin
                            m_presc = 0;
                            m_cnt = m_up ? m_cnt + 1 : m_cnt - 1;
                        end
                        if (m_ticked && at_end(m_up, m_cnt, m_tgt)) begin
                            m_st = M_EXP; m_pulse = 1'b1;
                        end else if (pause) m_st = M_PAUSE;
                    end
                    M_PAUSE: if (start) m_st = M_RUN;
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("running", 32'(running), 32'(m_st == M_RUN));
            cmp("expired", 32'(expired), 32'(m_st == M_EXP));
            cmp("expire_pulse", 32'(expire_pulse), 32'(m_pulse));
            cmp("count_bcd", 32'(count_bcd), 32'(to_bcd(m_cnt)));
            cmp("an", 32'(an), 32'(m_an));
            cmp("seg", 32'(seg), 32'(m_seg));
        end
        if (expire_pulse === 1'b1) pulse_seen++;
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe_load(input logic [15:0] v, input logic up);
        load = 1'b1; load_bcd = v; up_mode = up;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic strobe_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic strobe_pause;
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
    endtask

    int p0, nb, r;
    logic [15:0] lv;

    initial begin
        reset = 1'b1; load = 1'b0; load_bcd = '0; up_mode = 1'b0;
        start = 1'b0; pause = 1'b0;
        wait_cyc(3);
        cmp("rst_running", 32'(running), 32'(0));
        cmp("rst_count", 32'(count_bcd), 32'h0);
        cmp("rst_an", 32'(an), 32'hF);
        cmp("rst_seg", 32'(seg), 32'h7F);
        reset = 1'b0;
        wait_cyc(1);
        cmp("first_an", 32'(an), 32'hE);
        cmp("first_seg", 32'(seg), 32'h40);

        // Scan of 0x1234
        strobe_load(16'h1234, 1'b0);
        wait_cyc(2);
        cmp("scan0_an", 32'(an), 32'hE);  cmp("scan0_seg", 32'(seg), 32'h19);
        wait_cyc(4);
        cmp("scan1_an", 32'(an), 32'hD);  cmp("scan1_seg", 32'(seg), 32'h30);
        wait_cyc(4);
        cmp("scan2_an", 32'(an), 32'hB);  cmp("scan2_seg", 32'(seg), 32'h24);
        wait_cyc(4);
        cmp("scan3_an", 32'(an), 32'h7);  cmp("scan3_seg", 32'(seg), 32'h79);

        // Down count from 20
        strobe_load(16'h0020, 1'b0);
        p0 = pulse_seen;
        strobe_start;
        cmp("dn_running", 32'(running), 32'(1));
        wait_cyc(99);
        cmp("dn_pre_tick", 32'(count_bcd), 32'h0020);
        wait_cyc(1);
        cmp("dn_tick1", 32'(count_bcd), 32'h0019);
        wait_cyc(1899);
        cmp("dn_last", 32'(count_bcd), 32'h0001);
        cmp("dn_not_exp", 32'(expired), 32'(0));
        wait_cyc(1);
        cmp("dn_zero", 32'(count_bcd), 32'h0000);
        cmp("dn_expired", 32'(expired), 32'(1));
        cmp("dn_stopped", 32'(running), 32'(0));
        cmp("dn_pulse", 32'(expire_pulse), 32'(1));
        wait_cyc(1);
        cmp("dn_pulse_end", 32'(expire_pulse), 32'(0));
        cmp("dn_one_pulse", 32'(pulse_seen - p0), 32'(1));
`ifdef MATCH_TIMER_BLINK_EN
        nb = 0;
        repeat (100) begin
            @(negedge clk);
            if (an == 4'hF) nb++;
        end
        cmp("blink_blank_cycles", 32'(nb), 32'(50));
`endif

        // Up count to 105 with carries
        strobe_load(16'h0105, 1'b1);
        cmp("up_load", 32'(count_bcd), 32'h0000);
        strobe_start;
        wait_cyc(900);  cmp("up_9", 32'(count_bcd), 32'h0009);
        wait_cyc(100);  cmp("up_10", 32'(count_bcd), 32'h0010);
        wait_cyc(8900); cmp("up_99", 32'(count_bcd), 32'h0099);
        wait_cyc(100);  cmp("up_100", 32'(count_bcd), 32'h0100);
        wait_cyc(499);
        cmp("up_104", 32'(count_bcd), 32'h0104);
        cmp("up_not_exp", 32'(expired), 32'(0));
        wait_cyc(1);
        cmp("up_105", 32'(count_bcd), 32'h0105);
        cmp("up_expired", 32'(expired), 32'(1));
        cmp("up_pulse", 32'(expire_pulse), 32'(1));

        // Pause / resume keeps the partial second
        strobe_load(16'h0003, 1'b0);
        strobe_start;
        wait_cyc(149);
        strobe_pause;
        cmp("pz_count", 32'(count_bcd), 32'h0002);
        cmp("pz_running", 32'(running), 32'(0));
        wait_cyc(500);
        cmp("pz_frozen", 32'(count_bcd), 32'h0002);
        strobe_start;
        cmp("pz_resumed", 32'(running), 32'(1));
        wait_cyc(49);
        cmp("pz_pre_tick", 32'(count_bcd), 32'h0002);
        wait_cyc(1);
        cmp("pz_tick", 32'(count_bcd), 32'h0001);

        // Priority: load beats start and pause
        load = 1'b1; start = 1'b1; pause = 1'b1; load_bcd = 16'h0042; up_mode = 1'b0;
        @(negedge clk);
        load = 1'b0; start = 1'b0; pause = 1'b0;
        cmp("pri_running", 32'(running), 32'(0));
        cmp("pri_expired", 32'(expired), 32'(0));
        cmp("pri_count", 32'(count_bcd), 32'h0042);

        // Start at zero expires immediately; later start is ignored
        strobe_load(16'h0000, 1'b0);
        strobe_start;
        cmp("z_expired", 32'(expired), 32'(1));
        cmp("z_pulse", 32'(expire_pulse), 32'(1));
        strobe_start;
        cmp("z_ignored", 32'(expired), 32'(1));
        cmp("z_no_pulse", 32'(expire_pulse), 32'(0));

        // Digit sanitising
        strobe_load(16'h00AF, 1'b0);
        cmp("sanitise", 32'(count_bcd), 32'h0099);

        // Reset on the cycle that would have expired
        strobe_load(16'h0001, 1'b0);
        strobe_start;
        p0 = pulse_seen;
        wait_cyc(99);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp("mr_running", 32'(running), 32'(0));
        cmp("mr_expired", 32'(expired), 32'(0));
        cmp("mr_pulse", 32'(expire_pulse), 32'(0));
        cmp("mr_count", 32'(count_bcd), 32'h0);
        cmp("mr_an", 32'(an), 32'hF);
        cmp("mr_seg", 32'(seg), 32'h7F);
        wait_cyc(1);
        cmp("mr_an_rel", 32'(an), 32'hE);
        wait_cyc(200);
        cmp("mr_no_pulse", 32'(pulse_seen - p0), 32'(0));

        // Random strobes against the model
        for (int k = 0; k < 5000; k++) begin
            r = int'($urandom_range(0, 999));
            lv = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) lv = lv | (16'($urandom_range(0, 15)) << 4);
            if ($urandom_range(0, 15) == 0) lv = 16'($urandom);
            load_bcd = lv;
            up_mode  = 1'($urandom_range(0, 1));
            load  = (r < 4) || (r >= 34 && r < 36);
            start = (r >= 4 && r < 24) || (r >= 34 && r < 36);
            pause = (r >= 24 && r < 36);
            reset = (r == 999);
            @(negedge clk);
        end
        load = 1'b0; start = 1'b0; pause = 1'b0; reset = 1'b0;
        wait_cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
